keypad_scanner: RTL and testbench

//   Scans a 4x4 matrix keypad, debounces presses/releases and holds one key event in a sticky

---
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: MMIO read handshake plus the sticky key register.
interface keypad_scanner_if;
  logic        rd_ack;
  logic [31:0] key_data;
  logic        key_valid;
  logic        key_held;

  // MMIO controller side
  modport master (output rd_ack, input key_data, key_valid, key_held);
  // Peripheral side
  modport slave (input rd_ack, output key_data, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, column synchronizer, full-scan
// snapshot, debounce FSM and a sticky read-to-clear key event register.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              fpga_clk,
  input  logic              rst,
  input  logic [3:0]        col_in,
  output logic [3:0]        row_out,
  keypad_scanner_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  // cnt + 1 == DEBOUNCE_SCANS is tested as cnt == DEBOUNCE_SCANS - 1
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {IDLE, DEB_P, PRESSED, DEB_R} state_t;

  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [PW-1:0] presc;
  logic [1:0]    row;
  logic          tick;
  logic          scan_done;
  logic [3:0]    snap_row [4];
  logic [15:0]   snapshot;

  state_t        state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic          held;
  logic          valid;
  logic          overrun;
  logic [3:0]    code;

  logic [4:0]    bit_count;
  logic [3:0]    key_code;
  logic          key_single;
  logic          key_none;
  logic          post_event;

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  assign tick = (presc == PRESC_LAST);

  // Row dwell prescaler, row drive and end-of-scan pulse
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      row       <= 2'd0;
      row_out   <= 4'b1110;
      scan_done <= 1'b0;
    end else begin
      scan_done <= tick && (row == 2'd3);
      if (tick) begin
        presc   <= '0;
        row     <= row + 2'd1;
        row_out <= ~(4'b0001 << (row + 2'd1));
      end else begin
        presc   <= presc + 1'b1;
      end
    end
  end

  // One snapshot nibble per row, captured (as active-high) on that row's tick
  for (genvar gi = 0; gi < 4; gi++) begin : g_snap
    always_ff @(posedge fpga_clk or posedge rst) begin
      if (rst) begin
        snap_row[gi] <= 4'h0;
      end else if (tick && (row == 2'(gi))) begin
        snap_row[gi] <= ~col_sync;
      end
    end
    assign snapshot[4*gi +: 4] = snap_row[gi];
  end

  // Classify the snapshot: bit index of a lone key is directly {row, col}
  always_comb begin
    bit_count = 5'd0;
    key_code  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        bit_count = bit_count + 5'd1;
        key_code  = 4'(i);
      end
    end
  end

  assign key_single = (bit_count == 5'd1);
  assign key_none   = (bit_count == 5'd0);

  // A new event is posted exactly on the move into PRESSED from IDLE/DEB_P
  always_comb begin
    post_event = 1'b0;
    if (scan_done && key_single) begin
      if (state == IDLE && DEBOUNCE_SCANS == 1)
        post_event = 1'b1;
      else if (state == DEB_P && key_code == cand && cnt == CNT_LAST)
        post_event = 1'b1;
    end
  end

  // Debounce FSM with the sticky event register (valid/overrun/code)
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= 4'd0;
      cnt     <= '0;
      held    <= 1'b0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      code    <= 4'd0;
    end else begin
      // New event wins over a simultaneous read; read alone clears flags
      if (post_event) begin
        code    <= key_code;
        valid   <= 1'b1;
        overrun <= valid && !bus.rd_ack;
      end else if (bus.rd_ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end

      if (scan_done) begin
        case (state)
          IDLE: begin
            if (key_single) begin
              cand <= key_code;
              if (DEBOUNCE_SCANS == 1) begin
                state <= PRESSED;
                held  <= 1'b1;
                cnt   <= '0;
              end else begin
                state <= DEB_P;
                cnt   <= CW'(1);
              end
            end
          end
          DEB_P: begin
            if (key_single && key_code == cand) begin
              if (cnt == CNT_LAST) begin
                state <= PRESSED;
                held  <= 1'b1;
                cnt   <= '0;
              end else begin
                cnt   <= cnt + 1'b1;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (key_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                state <= IDLE;
                held  <= 1'b0;
                cnt   <= '0;
              end else begin
                state <= DEB_R;
                cnt   <= CW'(1);
              end
            end
          end
          DEB_R: begin
            if (key_none) begin
              if (cnt == CNT_LAST) begin
                state <= IDLE;
                held  <= 1'b0;
                cnt   <= '0;
              end else begin
                cnt   <= cnt + 1'b1;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            held  <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.key_data  = {valid, overrun, 25'b0, held, code};
  assign bus.key_valid = valid;
  assign bus.key_held  = held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// Expected key events are queued when a press is applied and popped when
// the DUT's held flag rises (the edge where an event is posted).
module tb_keypad_scanner;

  logic        fpga_clk;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] keys;
  int          checks;
  int          errors;
  logic [3:0]  exp_q[$];
  logic        prev_held;

  keypad_scanner_if bus();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .bus      (bus)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // Keypad matrix model: a pressed key pulls its column low while its row is driven
  always_comb begin
    logic [3:0] cols;
    cols = 4'b0000;
    for (int r = 0; r < 4; r++)
      if (!row_out[r]) cols = cols | keys[4*r +: 4];
    col_in = ~cols;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %08h t=%0t", tag, got, $time);
    end
  endtask

  // Scoreboard consumer: every held rise must match the oldest queued press
  always @(negedge fpga_clk) begin
    if (!rst && bus.key_held && !prev_held) begin
      chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("event_code", 32'(bus.key_data[3:0]), 32'(e));
        chk("event_valid", 32'(bus.key_valid), 32'd1);
      end
    end
    prev_held = bus.key_held;
  end

  // Advance to the negedge just after row 0 becomes active again
  task automatic next_scan();
    logic [3:0] last;
    int guard;
    last  = row_out;
    guard = 0;
    @(negedge fpga_clk);
    while (!(row_out == 4'b1110 && last == 4'b0111) && guard < 40) begin
      last = row_out;
      @(negedge fpga_clk);
      guard++;
    end
    chk("scan_sync_timeout", 32'(guard >= 40), 32'd0);
  endtask

  task automatic run_press(input int code);
    next_scan();
    keys = 16'h0001 << code;
    exp_q.push_back(4'(code));
    repeat (50) @(negedge fpga_clk);
  endtask

  task automatic run_release();
    next_scan();
    keys = 16'h0000;
    repeat (50) @(negedge fpga_clk);
  endtask

  task automatic pulse_ack();
    bus.rd_ack = 1'b1;
    @(negedge fpga_clk);
    bus.rd_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_data", bus.key_data, 32'h0);
    @(negedge fpga_clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_row;
    checks     = 0;
    errors     = 0;
    prev_held  = 1'b0;
    rst        = 1'b1;
    keys       = 16'h0;
    bus.rd_ack = 1'b0;
    repeat (3) @(negedge fpga_clk);
    rst = 1'b0;

    // 1: asynchronous reset mid-scan, then row sequencing
    repeat (7) @(negedge fpga_clk);
    chk("row_mid_scan", 32'(row_out), 32'(4'b1101));
    #2 rst = 1'b1;
    #1;
    chk("rst_row", 32'(row_out), 32'(4'b1110));
    chk("rst_data", bus.key_data, 32'h0);
    chk("rst_valid", 32'(bus.key_valid), 32'd0);
    chk("rst_held", 32'(bus.key_held), 32'd0);
    @(negedge fpga_clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge fpga_clk);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      chk("row_seq", 32'(row_out), 32'(exp_row));
    end

    // 2: press code 9 from a scan start, release, read
    next_scan();
    keys = 16'h0001 << 9;
    exp_q.push_back(4'd9);
    repeat (47) @(negedge fpga_clk);
    chk("t2_not_yet", 32'(bus.key_valid), 32'd0);
    repeat (3) @(negedge fpga_clk);
    chk("t2_press", bus.key_data, 32'h8000_0019);
    run_release();
    chk("t2_release", bus.key_data, 32'h8000_0009);
    pulse_ack();
    chk("t2_ack", bus.key_data, 32'h0000_0009);

    // 3: bounce on alternate scans, then hold -> one event
    next_scan();
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? (16'h0001 << 9) : 16'h0000;
      repeat (15) @(negedge fpga_clk);
      chk("t3_bounce", 32'(bus.key_valid), 32'd0);
      next_scan();
    end
    keys = 16'h0001 << 9;
    exp_q.push_back(4'd9);
    repeat (47) @(negedge fpga_clk);
    chk("t3_not_yet", 32'(bus.key_valid), 32'd0);
    repeat (3) @(negedge fpga_clk);
    chk("t3_press", bus.key_data, 32'h8000_0019);
    run_release();
    pulse_ack();
    chk("t3_ack", bus.key_data, 32'h0000_0009);

    // 4: two events without a read -> overrun
    run_press(5);
    chk("t4_first", bus.key_data, 32'h8000_0015);
    run_release();
    run_press(12);
    chk("t4_overrun", bus.key_data, 32'hC000_001C);
    run_release();
    chk("t4_release", bus.key_data, 32'hC000_000C);

    // 5: read on the exact post edge -> new event wins, overrun cleared
    next_scan();
    keys = 16'h0001 << 2;
    exp_q.push_back(4'd2);
    repeat (48) @(negedge fpga_clk);
    bus.rd_ack = 1'b1;
    @(negedge fpga_clk);
    bus.rd_ack = 1'b0;
    chk("t5_valid", 32'(bus.key_valid), 32'd1);
    chk("t5_overrun", 32'(bus.key_data[30]), 32'd0);
    chk("t5_data", bus.key_data, 32'h8000_0012);
    run_release();
    pulse_ack();
    chk("t5_ack", bus.key_data, 32'h0000_0002);

    // 6: ghost (two keys) never accepted; reset during DEB_P drops the press
    @(negedge fpga_clk);
    do_reset();
    next_scan();
    keys = (16'h0001 << 3) | (16'h0001 << 6);
    repeat (96) @(negedge fpga_clk);
    chk("t6_multi", bus.key_data, 32'h0000_0000);
    keys = 16'h0000;
    repeat (50) @(negedge fpga_clk);
    next_scan();
    keys = 16'h0001 << 7;
    repeat (20) @(negedge fpga_clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_row", 32'(row_out), 32'(4'b1110));
    chk("t6_rst_data", bus.key_data, 32'h0);
    keys = 16'h0000;
    @(negedge fpga_clk);
    rst = 1'b0;
    repeat (80) @(negedge fpga_clk);
    chk("t6_no_event", bus.key_data, 32'h0000_0000);

    chk("events_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
